// File: rtl/mm2s_ar_burst_gen_pkg.sv
// Shared parameters and types for the MM2S/S2MM address generators.
// Holds the AXI geometry, transfer-length width, burst/outstanding limits,
// the burst descriptor handed from the calculator to the issuing FSM, and
// the FSM state type.
package mm2s_ar_burst_gen_pkg;

    localparam int ADDR_WIDTH      = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int BYTE_LANES      = DATA_WIDTH / 8;
    localparam int LANE_BITS       = $clog2(BYTE_LANES);
    localparam int LEN_WIDTH       = 26;
    localparam int MAX_BURST_BEATS = 16;
    localparam int MAX_OUTSTANDING = 4;
    localparam int OUTS_WIDTH      = $clog2(MAX_OUTSTANDING + 1);
    localparam int BOUNDARY_BYTES  = 4096;
    localparam int BOUNDARY_BITS   = $clog2(BOUNDARY_BYTES);

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE       = 3'(LANE_BITS);

    // One burst: beat-aligned start address, AXI len (beats-1), and how many
    // of the remaining transfer bytes this burst actually delivers.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [LEN_WIDTH-1:0]  consumed;
    } burst_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ADDR  = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/mm2s_ar_burst_gen_calc.sv
// Combinational burst calculator (shared with the S2MM AW generator).
// Ports:
//   cur_addr_i   - current byte address of the transfer (any alignment)
//   bytes_left_i - bytes still to be requested (non-zero when used)
//   burst_o      - aligned burst address, AXI len, bytes consumed
// The burst is clipped to the remaining data, the max burst length and the
// next 4 KB boundary.
module mm2s_burst_calc
    import mm2s_ar_burst_gen_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0] cur_addr_i,
    input  logic [LEN_WIDTH-1:0]  bytes_left_i,
    output burst_t                burst_o
);

    // Wide enough for offset + length + rounding without overflow.
    localparam int CW = LEN_WIDTH + 2;

    logic [LANE_BITS-1:0]  off;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [CW-1:0]         need;
    logic [CW-1:0]         to4k;
    logic [CW-1:0]         beats;
    logic [CW-1:0]         span;

    always_comb begin
        off     = cur_addr_i[LANE_BITS-1:0];
        aligned = {cur_addr_i[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};
        need    = (CW'(off) + CW'(bytes_left_i) + CW'(BYTE_LANES - 1)) >> LANE_BITS;
        to4k    = (CW'(BOUNDARY_BYTES) - CW'(aligned[BOUNDARY_BITS-1:0])) >> LANE_BITS;

        beats = need;
        if (beats > CW'(MAX_BURST_BEATS)) beats = CW'(MAX_BURST_BEATS);
        if (beats > to4k)                 beats = to4k;

        // Bytes covered by the burst, minus the leading pad of the first beat.
        span = (beats << LANE_BITS) - CW'(off);

        burst_o.addr     = aligned;
        burst_o.len      = 8'(beats - CW'(1));
        burst_o.consumed = (span > CW'(bytes_left_i)) ? bytes_left_i
                                                      : span[LEN_WIDTH-1:0];
    end

endmodule

// File: rtl/mm2s_ar_burst_gen.sv
// MM2S read-address generator.
// Accepts one (address, length) command and issues AXI4 INCR bursts on AR,
// limiting issued-but-unreturned bursts via R-channel last-beat handshakes.
// Ports:
//   aclk, areset          - clock, synchronous active-high reset
//   cmd_valid/ready/addr/len - transfer command
//   m_axi_ar*             - AXI4 read address channel
//   rlast_hs              - rvalid & rready & rlast from the R channel
//   busy, done            - transfer in progress / one-cycle completion pulse
//   dbg_state_o           - current FSM state
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; a valid source holds its payload stable until then.
module mm2s_ar_burst_gen
    import mm2s_ar_burst_gen_pkg::*;
(
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic                  rlast_hs,
    output logic                  busy,
    output logic                  done,
    output state_e                dbg_state_o
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  bytes_left_q, bytes_left_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [LEN_WIDTH-1:0]  consumed_q, consumed_d;
    logic [OUTS_WIDTH-1:0] outs_q, outs_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    burst_t                burst;
    logic                  ar_hs;
    logic [8:0]            beats9;

    mm2s_burst_calc u_calc (
        .cur_addr_i   (cur_addr_q),
        .bytes_left_i (bytes_left_q),
        .burst_o      (burst)
    );

    assign ar_hs  = (state_q == ADDR) && m_axi_arready;
    assign beats9 = {1'b0, arlen_q} + 9'd1;

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        bytes_left_d = bytes_left_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        consumed_d   = consumed_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        // Empty transfer: complete immediately, no bursts.
                        done_d = 1'b1;
                    end else begin
                        cur_addr_d   = cmd_addr;
                        bytes_left_d = cmd_len;
                        busy_d       = 1'b1;
                        state_d      = CALC;
                    end
                end
            end
            CALC: begin
                araddr_d   = burst.addr;
                arlen_d    = burst.len;
                consumed_d = burst.consumed;
                if (outs_q < OUTS_WIDTH'(MAX_OUTSTANDING)) state_d = ADDR;
            end
            ADDR: begin
                if (m_axi_arready) begin
                    cur_addr_d   = araddr_q + (ADDR_WIDTH'(beats9) << LANE_BITS);
                    bytes_left_d = bytes_left_q - consumed_q;
                    state_d      = (bytes_left_d != '0) ? CALC : DRAIN;
                end
            end
            DRAIN: begin
                if (outs_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outstanding bursts: simultaneous issue and return cancel; a return
    // with nothing outstanding is dropped.
    always_comb begin
        outs_d = outs_q;
        if (ar_hs && !rlast_hs) begin
            outs_d = outs_q + OUTS_WIDTH'(1);
        end else if (!ar_hs && rlast_hs && (outs_q != '0)) begin
            outs_d = outs_q - OUTS_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            bytes_left_q <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            consumed_q   <= '0;
            outs_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            bytes_left_q <= bytes_left_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            consumed_q   <= consumed_d;
            outs_q       <= outs_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE) && !areset;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = (state_q == ADDR);
    assign busy          = busy_q;
    assign done          = done_q;
    assign dbg_state_o   = state_q;

endmodule

// File: doc/mm2s_ar_burst_gen.md
Name: mm2s_ar_burst_gen

Overview:
- MM2S read-address generator for the DMA. Accepts one transfer command (start byte address, byte length) and splits it into AXI4 INCR read bursts on the AR channel.
- Bursts honour MAX_BURST_BEATS, 4 KB boundaries and unaligned start addresses.
- Limits outstanding bursts by counting R-channel last-beat handshakes, and pulses done when the transfer is fully returned.
- Sits between the DMA command register stage and the AXI4 master read port, upstream of the R-data/byte-lane packing stage.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (multiple of 8)
BYTE_LANES, DATA_WIDTH/8, bytes per beat (power of 2)
LEN_WIDTH, 26, transfer length field width (bytes)
MAX_BURST_BEATS, 16, max beats per burst (1..256, power of 2)
MAX_OUTSTANDING, 4, max issued-but-unfinished bursts

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous reset, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_addr  in  ADDR_WIDTH  start byte address (any alignment)
cmd_len  in  LEN_WIDTH  transfer length in bytes
m_axi_araddr  out  ADDR_WIDTH  burst address (beat-aligned)
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  log2(BYTE_LANES)
m_axi_arburst  out  2  always 2'b01 (INCR)
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
rlast_hs  in  1  rvalid&rready&rlast from R channel
busy  out  1  high from command accept until done
done  out  1  one-cycle pulse at transfer completion

Behaviour:
- Reset values: cmd_ready=0 while areset is high; araddr=0, arlen=0, arsize=log2(BYTE_LANES), arburst=2'b01, arvalid=0, busy=0, done=0, outstanding=0, state=IDLE.
- FSM states: IDLE, CALC, ADDR, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch cur_addr=cmd_addr and bytes_left=cmd_len; busy=1; go to CALC.
  - If cmd_len==0: no AR is issued; done pulses on the next cycle; stay in IDLE.
- CALC:
  - Derive: off = cur_addr mod BYTE_LANES; aligned = cur_addr - off.
  - need = ceil((off+bytes_left)/BYTE_LANES).
  - to4k = (4096 - aligned[11:0]) / BYTE_LANES.
  - beats = min(need, MAX_BURST_BEATS, to4k).
  - consumed = min(beats*BYTE_LANES - off, bytes_left).
  - Register araddr=aligned and arlen=beats-1.
  - Go to ADDR only when outstanding < MAX_OUTSTANDING; otherwise hold in CALC.
- ADDR:
  - arvalid=1; araddr, arlen, arsize and arburst stay stable until arready.
  - On handshake: arvalid drops next cycle; cur_addr=aligned+beats*BYTE_LANES; bytes_left-=consumed; outstanding+1.
  - Next state: CALC if bytes_left>0, else DRAIN.
- DRAIN: when outstanding==0, pulse done for one cycle, clear busy, go to IDLE.
- Outstanding counter: AR handshake gives +1, rlast_hs gives -1. Both in the same cycle leave it unchanged. rlast_hs at 0 is ignored (no underflow).
- Latency: command accepted at cycle N -> arvalid high at N+2. Back-to-back bursts: arvalid is low for exactly one cycle (CALC) between handshakes.
- Reset mid-operation: every register returns to its reset value at that edge; no done pulse. Pending R beats are the bench/system's responsibility.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Burst lengths are always computed so that no burst crosses a 4 KB boundary.

Decomposition:
- Shared params package gains: LEN_WIDTH, MAX_BURST_BEATS, MAX_OUTSTANDING, AXI_BURST_INCR=2'b01, BOUNDARY_BYTES=4096, and typedef struct burst_t {addr, len[7:0], consumed}.
- One combinational sub-module, mm2s_burst_calc: (cur_addr, bytes_left) -> burst_t. It is reused by the S2MM AW generator.

Test Plan:
1. DATA_WIDTH 32, cmd addr 0x1000, len 64 -> one AR (araddr 0x1000, arlen 15, arsize 2, arburst 01). One rlast_hs -> done pulse, busy low.
2. Addr 0x0FF0, len 32 -> AR1 araddr 0x0FF0, arlen 3; AR2 araddr 0x1000, arlen 3. No 4 KB crossing.
3. Addr 0x2003, len 6 -> single AR araddr 0x2000, arlen 2. Done after one rlast_hs.
4. Addr 0x0, len 400, rlast_hs withheld -> four ARs (arlen 15) issued, then the FSM holds in CALC. Each rlast_hs releases the next burst (16 beats, then 4 beats, arlen 3). Done after 7 rlast_hs.
5. arready held low 5 cycles during ADDR -> arvalid, araddr and arlen stable every cycle. Handshake on cycle 6.
6. areset pulsed while in ADDR -> arvalid=0 and cmd_ready=0 during reset, cmd_ready=1 after release, no done. A new len 0 command -> done one cycle after accept, no AR.
